// File: rtl/mult_div_sequencer_pkg.sv
// mult_div_sequencer_pkg: shared state encodings and op/HI-LO select constants
package mult_div_sequencer_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_WRITE, ST_DZERO} state_t;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam logic HILO_SEL_MULT = 1'b0;
  localparam logic HILO_SEL_DIV = 1'b1;
endpackage

// File: rtl/mult_div_sequencer_step_counter.sv
// mult_div_sequencer_step_counter: loadable down-counter that saturates at zero
module mult_div_sequencer_step_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clock)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - CNT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: sequences load, WIDTH step cycles and HI/LO write for the iterative mult/div
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             load,
  output logic             mult_step,
  output logic             div_step,
  output logic             hi_write,
  output logic             lo_write,
  output logic             hilo_sel
);
  state_t state, state_n;
  logic op_q, cnt_zero, accept, dz;
  assign accept = state == ST_IDLE && start && !flush;
  assign dz = op == OP_DIV && operand_b == '0;
  mult_div_sequencer_step_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .load(state == ST_LOAD),
    .dec(state == ST_RUN),
    .load_val(CNT_W'(WIDTH - 1)),
    .zero(cnt_zero)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= ST_IDLE;
      op_q <= OP_MULT;
    end else begin
      state <= state_n;
      if (accept && !dz) op_q <= op;
    end
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  state_n = accept ? (dz ? ST_DZERO : ST_LOAD) : ST_IDLE;
      ST_LOAD:  state_n = ST_RUN;
      ST_RUN:   state_n = cnt_zero ? ST_WRITE : ST_RUN;
      ST_WRITE: state_n = ST_IDLE;
      ST_DZERO: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    if (flush) state_n = ST_IDLE;
  end
  assign busy = state != ST_IDLE;
  assign done = state == ST_WRITE;
  assign div_zero = state == ST_DZERO;
  assign load = state == ST_LOAD;
  assign mult_step = state == ST_RUN && op_q == OP_MULT;
  assign div_step = state == ST_RUN && op_q == OP_DIV;
  assign hi_write = state == ST_WRITE;
  assign lo_write = state == ST_WRITE;
  assign hilo_sel = op_q == OP_DIV ? HILO_SEL_DIV : HILO_SEL_MULT;
endmodule
